// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO with occupancy count, programmable
//   almost-full / almost-empty thresholds and one-cycle overflow / underflow
//   error pulses. Storage is an inferred RAM array with a registered read port.
//
// Parameters
//   DATA_W     data word width in bits (>= 1)
//   DEPTH      number of entries (>= 2, any integer)
//   AF_THRESH  almost_full  when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty when count <= AE_THRESH (0..DEPTH-1)
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   wr, din       write request and write data
//   rd, dout      read request and registered read data
//   full, empty   count == DEPTH / count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         current occupancy
//   overflow      one-cycle pulse after a rejected write
//   underflow     one-cycle pulse after a rejected read
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0]     wptr_reg, wptr_next;
    logic [PW-1:0]     rptr_reg, rptr_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [DATA_W-1:0] dout_reg;
    logic              overflow_reg, underflow_reg;
    logic              wr_ok, rd_ok;

    // Pointers wrap explicitly so that non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Flags decode the registered count only, so they never glitch.
    always_comb begin
        full         = (count_reg == CW'(DEPTH));
        empty        = (count_reg == '0);
        almost_full  = (count_reg >= CW'(AF_THRESH));
        almost_empty = (count_reg <= CW'(AE_THRESH));
    end

    // A full FIFO still accepts a write when a read frees a slot in the same
    // cycle; an empty FIFO never forwards the incoming word to the read side.
    always_comb begin
        wr_ok = wr && (!full || rd);
        rd_ok = rd && !empty;
    end

    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        count_next = count_reg;
        if (wr_ok) begin
            wptr_next = ptr_inc(wptr_reg);
        end
        if (rd_ok) begin
            rptr_next = ptr_inc(rptr_reg);
        end
        if (wr_ok && !rd_ok) begin
            count_next = count_reg + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem[wptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            dout_reg      <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            count_reg     <= count_next;
            // Read-first on a simultaneous read/write at the same slot
            // (full FIFO): the old word is returned.
            if (rd_ok) begin
                dout_reg <= mem[rptr_reg];
            end
            overflow_reg  <= wr && full && !rd;
            underflow_reg <= rd && empty;
        end
    end

    assign dout      = dout_reg;
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous single-clock FIFO, the next generation of the team's fixed-size `fifo`. It keeps the `wr`/`rd`/`din`/`dout`/`full`/`empty` port set unchanged, so existing testbench interfaces bind without edits. It adds the following:
- configurable data width and depth;
- an occupancy count output;
- programmable almost-full and almost-empty thresholds;
- single-cycle overflow and underflow error pulses.

It sits between producer and consumer stages in the same clock domain.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 16, number of storage entries (≥2, any integer, not restricted to powers of two)
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)
- CW (local), $clog2(DEPTH+1), count width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wr  in  1  write request
- rd  in  1  read request
- din  in  DATA_W  write data
- dout  out  DATA_W  read data, registered
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  CW  current occupancy
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- **Storage.** DEPTH×DATA_W array, write pointer and read pointer, each 0..DEPTH-1. Each pointer wraps explicitly to 0 after DEPTH-1; this is required for non-power-of-two depths.
- **Accepted write:** wr && (!full || rd). din is stored at wptr and wptr advances.
- **Accepted read:** rd && !empty. mem[rptr] is loaded into dout and rptr advances.
- **rd && wr when full:** both are accepted; count is unchanged and there is no overflow.
- **rd && wr when empty:** the write is accepted and the read is rejected. underflow pulses, count becomes 1, and dout holds its value. There is no fall-through.
- **wr when full without rd:** the write is dropped, overflow = 1 for one cycle, and state is unchanged.
- **rd when empty:** the read is dropped, underflow = 1 for one cycle, and dout holds.
- **count update:** +1 on write only, -1 on read only, unchanged on both or neither. count never exceeds DEPTH and never goes below 0.
- **Flags:** full, empty, almost_full and almost_empty are combinational decodes of the registered count, so they are glitch-free relative to clk.
- **dout between reads:** dout holds the last read word when no read is accepted.
- **Reset** (rst high at a rising edge) overrides wr and rd in the same cycle. Pointers = 0, count = 0, dout = 0, overflow = 0, underflow = 0. Memory contents are not cleared but become unreachable. Reset mid-operation discards all stored words.

## Timing
- Reset values: dout = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0 (given AF_THRESH ≥ 1), overflow = 0, underflow = 0.
- **Write latency:** a write accepted at edge n makes count, empty and the almost flags reflect it after edge n. The word is readable by a rd sampled at edge n+1.
- **Read latency:** a read accepted at edge n presents data on dout after edge n, i.e. one cycle after rd is driven.
- **Error pulses:** overflow and underflow are registered and high for exactly the cycle following the offending edge. They stay high on back-to-back rejections.
- **Handshake:** the producer and consumer may hold wr and rd high continuously. Acceptance is decided each edge from the pre-edge count.

## Test plan
Parameters for all scenarios: DATA_W = 8, DEPTH = 16, AF_THRESH = 14, AE_THRESH = 2.
1. **Reset values.** Assert rst for 2 cycles with wr = 1 → count = 0, empty = 1, almost_empty = 1, full = 0, dout = 0, and no write occurs.
2. **Fill and drain.** Write 0x00..0x0F over 16 cycles → almost_full rises when count = 14, full rises when count = 16, and a 17th write gives overflow = 1 for one cycle with count = 16. Then read 16 times → dout = 0x00..0x0F in order, each one cycle after its rd. A 17th read gives underflow = 1 and dout holds 0x0F.
3. **Simultaneous read and write at full.** rd = wr = 1 with din = 0xAA → count stays 16, no overflow, and dout = the oldest word. After draining, 0xAA emerges last.
4. **Simultaneous read and write at empty.** rd = wr = 1 with din = 0x55 → underflow pulse, count = 1, dout unchanged. The next rd returns 0x55.
5. **Wrap-around.** Run 40 cycles of continuous rd = wr = 1 after pre-loading 5 words, with an incrementing pattern → count stays 5 and output order is preserved across the pointer wrap. Repeat with DEPTH = 12 (non-power-of-two).
6. **Reset mid-operation.** Load 7 words, then assert rst with rd = 1 → the rd is ignored, count = 0, empty = 1, dout = 0. Subsequent writes of 0x11 and 0x22 read back as 0x11 then 0x22.
